// File: rtl/fft_twiddle_sequencer.sv
// rtl/fft_twiddle_sequencer.sv - radix-2 DIT FFT stage/butterfly sequencer with twiddle ROM addressing
module fft_twiddle_sequencer #(
  parameter int LOG_N        = 4,
  parameter int FLUSH_CYCLES = 4,
  parameter int STAGE_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               bf_valid,
  input  logic               bf_ready,
  output logic [STAGE_W-1:0] bf_stage,
  output logic [LOG_N-1:0]   bf_idx_a,
  output logic [LOG_N-1:0]   bf_idx_b,
  output logic               bf_last,
  output logic [LOG_N-2:0]   tw_addr,
  output logic               tw_addr_nd
);

  localparam int KW = LOG_N - 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [KW-1:0]      K_LAST = {KW{1'b1}};
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG_N - 1);
  localparam logic [FW-1:0]      F_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t             state, n_state;
  logic [STAGE_W-1:0] stage, n_stage;
  logic [KW-1:0]      k, n_k;
  logic [FW-1:0]      fcnt, n_fcnt;
  logic               fire;

  logic [LOG_N-1:0]   kx, half, pos, grp, n_idx_a, n_idx_b;
  logic [STAGE_W-1:0] tw_sh;
  logic [KW-1:0]      n_tw;

  assign fire       = bf_valid & bf_ready;
  assign tw_addr_nd = fire;

  always_comb begin
    n_state = state;
    n_stage = stage;
    n_k     = k;
    n_fcnt  = fcnt;
    case (state)
      IDLE: begin
        if (start) begin
          n_state = RUN;
          n_stage = '0;
          n_k     = '0;
          n_fcnt  = '0;
        end
      end
      RUN: begin
        if (fire) begin
          if (k == K_LAST) begin
            n_k = '0;
            if (stage == S_LAST) begin
              n_state = DONE;
            end else begin
              n_state = FLUSH;
              n_stage = stage + STAGE_W'(1);
              n_fcnt  = '0;
            end
          end else begin
            n_k = k + KW'(1);
          end
        end
      end
      FLUSH: begin
        if (fcnt == F_LAST) n_state = RUN;
        else                n_fcnt  = fcnt + FW'(1);
      end
      DONE: n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  // Indices are derived from the next (stage, k) so the command registers line up with the state.
  always_comb begin
    kx      = {1'b0, n_k};
    half    = LOG_N'(1) << n_stage;
    pos     = kx & (half - LOG_N'(1));
    grp     = kx >> n_stage;
    n_idx_a = ((grp << n_stage) << 1) | pos;
    n_idx_b = n_idx_a + half;
    tw_sh   = S_LAST - n_stage;
    n_tw    = KW'(pos << tw_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stage    <= '0;
      k        <= '0;
      fcnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bf_valid <= 1'b0;
      bf_stage <= '0;
      bf_idx_a <= '0;
      bf_idx_b <= '0;
      bf_last  <= 1'b0;
      tw_addr  <= '0;
    end else begin
      state    <= n_state;
      stage    <= n_stage;
      k        <= n_k;
      fcnt     <= n_fcnt;
      busy     <= (n_state == RUN) || (n_state == FLUSH);
      done     <= (n_state == DONE);
      bf_valid <= (n_state == RUN);
      if (n_state == RUN) begin
        bf_stage <= n_stage;
        bf_idx_a <= n_idx_a;
        bf_idx_b <= n_idx_b;
        bf_last  <= (n_stage == S_LAST) && (n_k == K_LAST);
        tw_addr  <= n_tw;
      end else begin
        bf_stage <= '0;
        bf_idx_a <= '0;
        bf_idx_b <= '0;
        bf_last  <= 1'b0;
        tw_addr  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// tb/tb_fft_twiddle_sequencer.sv - directed self-checking bench for fft_twiddle_sequencer
module tb_fft_twiddle_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, bf_ready;
  logic       busy, done, bf_valid, bf_last, tw_addr_nd;
  logic [1:0] bf_stage;
  logic [3:0] bf_idx_a, bf_idx_b;
  logic [2:0] tw_addr;

  int n_pass = 0;
  int n_chk  = 0;

  logic r_fire[64], r_done[64], r_busy[64], r_valid[64], r_last[64], r_nd[64];
  int   r_a[64], r_b[64], r_tw[64], r_s[64];

  int done_cyc, done_cnt, nd_cnt, last_cyc, last_cnt, mis, bad;

  fft_twiddle_sequencer #(.LOG_N(4), .FLUSH_CYCLES(4), .STAGE_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_stage(bf_stage),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_last(bf_last),
    .tw_addr(tw_addr), .tw_addr_nd(tw_addr_nd)
  );

  always #5 clk = ~clk;

  `define CHK(tag, obs, exp) begin \
    n_chk++; \
    assert ((obs) === (exp)) begin n_pass++; end \
    else begin $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end \
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle start is asserted; cycle c is sampled c edges later.
  task automatic run(input int ncyc, input int stall_lo, input int stall_hi,
                     input int pulse_at, input bit hold);
    start    = 1'b1;
    bf_ready = 1'b1;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      start    = hold || (c == pulse_at);
      bf_ready = !(c >= stall_lo && c <= stall_hi);
      #1;
      r_fire[c]  = bf_valid & bf_ready;
      r_nd[c]    = tw_addr_nd;
      r_done[c]  = done;
      r_busy[c]  = busy;
      r_valid[c] = bf_valid;
      r_last[c]  = bf_last;
      r_a[c]     = int'(bf_idx_a);
      r_b[c]     = int'(bf_idx_b);
      r_tw[c]    = int'(tw_addr);
      r_s[c]     = int'(bf_stage);
      if (c < ncyc) tick();
    end
  endtask

  task automatic summarize(input int ncyc);
    done_cyc = -1; done_cnt = 0; nd_cnt = 0; last_cyc = -1; last_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (r_done[c]) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (r_nd[c]) nd_cnt++;
      if (r_last[c]) begin last_cnt++; last_cyc = c; end
    end
  endtask

  function automatic bit exp_fire(input int c);
    return (c >= 1 && c <= 8) || (c >= 13 && c <= 20) ||
           (c >= 25 && c <= 32) || (c >= 37 && c <= 44);
  endfunction

  task automatic fire_mismatches(input int ncyc);
    mis = 0;
    for (int c = 1; c <= ncyc; c++)
      if (r_fire[c] !== exp_fire(c)) mis++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bf_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    `CHK("rst_busy", busy, 1'b0)
    `CHK("rst_done", done, 1'b0)
    `CHK("rst_valid", bf_valid, 1'b0)
    `CHK("rst_nd", tw_addr_nd, 1'b0)
    `CHK("rst_idx_a", bf_idx_a, 4'd0)
    `CHK("rst_idx_b", bf_idx_b, 4'd0)
    `CHK("rst_tw", tw_addr, 3'd0)
    `CHK("rst_last", bf_last, 1'b0)
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({busy, done, bf_valid, tw_addr_nd, bf_last} !== 5'b0 ||
          bf_idx_a !== 4'd0 || bf_idx_b !== 4'd0 || tw_addr !== 3'd0) bad++;
    end
    `CHK("idle_10_cycles", bad, 0)

    // Full transform with a start pulse during FLUSH that must be ignored.
    run(50, 0, -1, 10, 1'b0);
    start = 1'b0;
    summarize(50);
    fire_mismatches(50);
    `CHK("full_fire_pattern", mis, 0)
    `CHK("full_done_cycle", done_cyc, 45)
    `CHK("full_done_count", done_cnt, 1)
    `CHK("full_nd_count", nd_cnt, 32)
    `CHK("s0k0_a", r_a[1], 0)
    `CHK("s0k0_b", r_b[1], 1)
    `CHK("s0k0_tw", r_tw[1], 0)
    `CHK("s1k1_s", r_s[14], 1)
    `CHK("s1k1_a", r_a[14], 1)
    `CHK("s1k1_b", r_b[14], 3)
    `CHK("s1k1_tw", r_tw[14], 4)
    `CHK("s2k5_a", r_a[30], 9)
    `CHK("s2k5_b", r_b[30], 13)
    `CHK("s2k5_tw", r_tw[30], 2)
    `CHK("s3k5_s", r_s[42], 3)
    `CHK("s3k5_a", r_a[42], 5)
    `CHK("s3k5_b", r_b[42], 13)
    `CHK("s3k5_tw", r_tw[42], 5)
    `CHK("last_cycle", last_cyc, 44)
    `CHK("last_count", last_cnt, 1)
    `CHK("last_a", r_a[44], 7)
    `CHK("last_b", r_b[44], 15)
    `CHK("last_tw", r_tw[44], 7)
    `CHK("flush_busy", r_busy[10], 1'b1)
    `CHK("flush_valid", r_valid[10], 1'b0)
    `CHK("done_busy", r_busy[45], 1'b0)

    // Backpressure: bf_ready low on cycles 15..17 at s=1,k=2.
    run(52, 15, 17, 0, 1'b0);
    summarize(52);
    `CHK("bp_a_first", r_a[15], 4)
    `CHK("bp_b_first", r_b[15], 6)
    `CHK("bp_tw_first", r_tw[15], 0)
    `CHK("bp_nd_first", r_nd[15], 1'b0)
    `CHK("bp_s_held", r_s[17], 1)
    `CHK("bp_a_held", r_a[17], 4)
    `CHK("bp_b_held", r_b[17], 6)
    `CHK("bp_nd_held", r_nd[17], 1'b0)
    `CHK("bp_fire_release", r_fire[18], 1'b1)
    `CHK("bp_a_release", r_a[18], 4)
    `CHK("bp_a_next", r_a[19], 5)
    `CHK("bp_done_cycle", done_cyc, 48)
    `CHK("bp_nd_count", nd_cnt, 32)

    // start held high: the second run may only begin after DONE.
    run(48, 0, -1, 0, 1'b1);
    summarize(48);
    `CHK("hold_done_cycle", done_cyc, 45)
    `CHK("hold_done_count", done_cnt, 1)
    `CHK("hold_idle_valid", r_valid[46], 1'b0)
    `CHK("hold_idle_busy", r_busy[46], 1'b0)
    `CHK("hold_restart_fire", r_fire[47], 1'b1)
    `CHK("hold_restart_a", r_a[47], 0)
    `CHK("hold_restart_s", r_s[47], 0)
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Abort at s=2,k=3.
    run(28, 0, -1, 0, 1'b0);
    `CHK("abort_pt_s", r_s[28], 2)
    `CHK("abort_pt_a", r_a[28], 3)
    `CHK("abort_pt_b", r_b[28], 7)
    `CHK("abort_pt_tw", r_tw[28], 6)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    `CHK("abort_busy", busy, 1'b0)
    `CHK("abort_done", done, 1'b0)
    `CHK("abort_valid", bf_valid, 1'b0)
    `CHK("abort_a", bf_idx_a, 4'd0)
    `CHK("abort_b", bf_idx_b, 4'd0)
    `CHK("abort_tw", tw_addr, 3'd0)
    `CHK("abort_stage", bf_stage, 2'd0)
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    `CHK("abort_no_done", bad, 0)

    run(46, 0, -1, 0, 1'b0);
    summarize(46);
    fire_mismatches(46);
    `CHK("clean_fire_pattern", mis, 0)
    `CHK("clean_first_s", r_s[1], 0)
    `CHK("clean_first_a", r_a[1], 0)
    `CHK("clean_done_cycle", done_cyc, 45)
    `CHK("clean_nd_count", nd_cnt, 32)

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_twiddle_sequencer.md
Name: fft_twiddle_sequencer

Overview:
Control block for the radix-2 decimation-in-time FFT datapath. It steps through every stage and butterfly of an N-point transform. For each butterfly it drives the twiddle-factor ROM address and strobe, and issues the butterfly operand indices to the butterfly/memory datapath over a valid/ready handshake. Between stages it inserts a fixed flush gap so the butterfly pipeline drains before the next stage reads its results.

Parameters:
LOG_N, 4, log2 of FFT length N (N=16 default); twiddle ROM holds N/2 entries.
FLUSH_CYCLES, 4, idle cycles inserted between consecutive stages (>=1).
STAGE_W, 2, width of stage index; must satisfy 2^STAGE_W >= LOG_N.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request one full transform; sampled only in IDLE.
busy  out  1  high in RUN and FLUSH.
done  out  1  one-cycle pulse after the last butterfly of the last stage fires.
bf_valid  out  1  butterfly command valid.
bf_ready  in  1  datapath accepts command.
bf_stage  out  STAGE_W  current stage s, 0..LOG_N-1.
bf_idx_a  out  LOG_N  upper-leg sample index.
bf_idx_b  out  LOG_N  lower-leg sample index (= idx_a + 2^s).
bf_last  out  1  high with the final butterfly of the final stage.
tw_addr  out  LOG_N-1  twiddle ROM address, same cycle as command.
tw_addr_nd  out  1  twiddle ROM strobe = bf_valid & bf_ready (combinational).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- States: IDLE, RUN, FLUSH, DONE. Reset -> IDLE, stage=0, k=0, flush counter=0. All registered outputs reset to 0: busy, done, bf_valid, bf_stage, bf_idx_a, bf_idx_b, bf_last, tw_addr. tw_addr_nd is 0 in reset because bf_valid=0.
- IDLE: start=1 -> RUN next cycle with s=0, k=0. start=0 -> stay.
- Butterfly counter k runs 0..N/2-1 within each stage. Fire = bf_valid & bf_ready.
- Index arithmetic (unsigned, no overflow by construction): half=2^s, pos=k & (half-1), grp=k>>s.
  - idx_a = grp*2*half + pos
  - idx_b = idx_a + half
  - tw_addr = pos << (LOG_N-1-s)
- RUN: bf_valid=1. Outputs are stable while bf_ready=0; no advance without fire.
  - On fire with k<N/2-1: k++ and the next command is presented the following cycle, giving back-to-back issue at 1 per cycle.
  - On fire with k=N/2-1 and s<LOG_N-1: go to FLUSH, k=0, s++.
  - On fire with k=N/2-1 and s=LOG_N-1: go to DONE.
- bf_last=1 only when s=LOG_N-1 and k=N/2-1.
- FLUSH: bf_valid=0. Counts FLUSH_CYCLES cycles, then returns to RUN with the new stage's k=0 command.
- DONE: done=1 for exactly one cycle, busy=0, bf_valid=0, then IDLE. The earliest re-accepted start is the cycle after DONE.
- start outside IDLE is ignored and not queued.
- rst mid-transform aborts immediately: next cycle is IDLE with all outputs at reset values and no done pulse.
- bf_ready high in IDLE/FLUSH/DONE has no effect.
- The twiddle ROM returns data one cycle after tw_addr_nd. Aligning that data with the command is the datapath's job.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=done=bf_valid=tw_addr_nd=0 and indices 0 for 10 cycles.
- Full run, bf_ready tied high, N=16, FLUSH_CYCLES=4, start pulsed at cycle 0:
  - Fires occur on cycles 1-8, 13-20, 25-32 and 37-44.
  - done=1 on cycle 45 only.
  - Exactly 32 tw_addr_nd pulses.
- Index checks during the full run:
  - s=0,k=0 -> a=0,b=1,tw=0.
  - s=1,k=1 -> a=1,b=3,tw=4.
  - s=2,k=5 -> a=9,b=13,tw=2.
  - s=3,k=5 -> a=5,b=13,tw=5.
  - bf_last only at s=3,k=7 (a=7,b=15,tw=7).
- Backpressure: drop bf_ready for 3 cycles at s=1,k=2 -> a=4,b=6,tw=0 held with tw_addr_nd=0, then one fire; the total done cycle shifts by exactly 3.
- start asserted continuously throughout a run -> second run begins only after DONE; start pulses while busy produce no extra transform.
- rst asserted at s=2,k=3 -> next cycle IDLE, all outputs 0, no done; a subsequent start runs a clean transform from s=0,k=0.
